// File: rtl/bs_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package bs_pkg;

    typedef enum logic [1:0] {
        BS_SLL = 2'b00,
        BS_SRL = 2'b01,
        BS_SRA = 2'b10,
        BS_ROR = 2'b11
    } bs_mode_e;

    function automatic int bs_shw(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bs_shift_stage.sv
// One mux level of the barrel shifter: conditional shift by 2^STAGE, its
// pipeline register and the stage's valid/ready handshake.
module bs_shift_stage
    import bs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = bs_shw(WIDTH),
    parameter int TAG_W = 4,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  bs_mode_e         mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   shamt_o,
    output bs_mode_e         mode_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o
);

    localparam int DIST = 1 << STAGE;

    logic             valid_q;
    logic [WIDTH-1:0] data_q, data_d, shifted;
    logic [SHW-1:0]   shamt_q;
    bs_mode_e         mode_q;
    logic [TAG_W-1:0] tag_q;

    // An empty stage always accepts, so bubbles close up even under back-pressure.
    assign ready_o = ~valid_q | ready_i;

    always_comb begin
        shifted = data_i;
        case (mode_i)
            BS_SLL:  shifted = data_i << DIST;
            BS_SRL:  shifted = data_i >> DIST;
            BS_SRA:  shifted = {{DIST{data_i[WIDTH-1]}}, data_i[WIDTH-1:DIST]};
            BS_ROR:  shifted = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
            default: shifted = data_i;
        endcase
        data_d = shamt_i[STAGE] ? shifted : data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= BS_SLL;
            tag_q   <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            shamt_q <= shamt_i;
            mode_q  <= mode_i;
            tag_q   <= tag_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;
    assign tag_o   = tag_q;

    // Only the final level drives the zero flag; it is registered alongside data.
    if (STAGE == SHW - 1) begin : g_zero
        logic zero_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zero_q <= 1'b0;
            end else if (ready_o) begin
                zero_q <= ~|data_d;
            end
        end
        assign zero_o = zero_q;
    end else begin : g_no_zero
        assign zero_o = 1'b0;
    end

endmodule

// File: rtl/bs_pipe_shifter.sv
// Pipelined barrel shifter/rotator: SHW registered mux levels with a
// valid/ready handshake and a pass-through tag.
module bs_pipe_shifter
    import bs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = bs_shw(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam int N = SHW;

    logic             v_w     [0:N];
    logic             rdy_w   [0:N];
    logic [WIDTH-1:0] data_w  [0:N];
    logic [SHW-1:0]   shamt_w [0:N];
    bs_mode_e         mode_w  [0:N];
    logic [TAG_W-1:0] tag_w   [0:N];
    logic             zero_w  [0:N-1];

    assign v_w[0]     = in_valid;
    assign data_w[0]  = in_data;
    assign shamt_w[0] = in_shamt;
    assign mode_w[0]  = bs_mode_e'(in_mode);
    assign tag_w[0]   = in_tag;
    assign rdy_w[N]   = out_ready;
    assign in_ready   = rdy_w[0];

    for (genvar k = 0; k < N; k++) begin : g_stage
        bs_shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .TAG_W (TAG_W),
            .STAGE (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (v_w[k]),
            .ready_o (rdy_w[k]),
            .data_i  (data_w[k]),
            .shamt_i (shamt_w[k]),
            .mode_i  (mode_w[k]),
            .tag_i   (tag_w[k]),
            .valid_o (v_w[k+1]),
            .ready_i (rdy_w[k+1]),
            .data_o  (data_w[k+1]),
            .shamt_o (shamt_w[k+1]),
            .mode_o  (mode_w[k+1]),
            .tag_o   (tag_w[k+1]),
            .zero_o  (zero_w[k])
        );
    end

    assign out_valid = v_w[N];
    assign out_data  = data_w[N];
    assign out_tag   = tag_w[N];
    assign out_zero  = zero_w[N-1];

    // Shift amount and mode are spent after the last level; early zero flags are tied off.
    logic unused_tail;
    always_comb begin
        unused_tail = ^{shamt_w[N], mode_w[N]};
        for (int k = 0; k < N - 1; k++) begin
            unused_tail = unused_tail ^ zero_w[k];
        end
    end

endmodule

// File: tb/tb_bs_pipe_shifter.sv
// Scoreboard bench for bs_pipe_shifter (WIDTH=8): directed vectors, streaming,
// back-pressure, mid-flight reset and random ready toggling.
module tb_bs_pipe_shifter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int TAG_W = 4;
    localparam int TMO   = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    bs_pipe_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        int               acc;
        bit               lat;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [1:0] m;
        logic [7:0] e;
    } vec_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;
    logic [TAG_W-1:0] tag_ctr = '0;
    bit rnd_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = d << s;
            2'd1:    r = d >> s;
            2'd2:    r = 8'($signed(d) >>> s);
            default: r = (d >> s) | (d << (8 - s));
        endcase
        return r;
    endfunction

    // Drive one word and push its expectation on the accepting edge.
    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                        input logic [7:0] e, input bit lat, output int waited);
        bit done = 1'b0;
        waited = 0;
        in_data = d; in_shamt = s; in_mode = m; in_tag = tag_ctr; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{data: e, tag: tag_ctr, acc: cyc, lat: lat});
                n_vec++;
                done = 1'b1;
            end else if (waited >= TMO) begin
                n_err++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops on every output transfer and checks hold stability.
    initial begin
        bit               hold = 1'b0;
        logic [WIDTH-1:0] hold_data;
        logic [TAG_W-1:0] hold_tag;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, hold_data);
                    chk("hold_tag", out_tag, hold_tag);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_output: got data %0h tag %0h, expected no word", out_data, out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_tag", out_tag, e.tag);
                        chk("out_zero", out_zero, (e.data == 0) ? 1 : 0);
                        if (e.lat) chk("latency", cyc - e.acc, 3);
                    end
                end
                hold      = out_valid && !out_ready;
                hold_data = out_data;
                hold_tag  = out_tag;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        vec_t dv[13];
        int   w, t0;
        logic [7:0] d, e;
        logic [2:0] s;
        logic [1:0] m;

        dv = '{
            '{8'hB5, 3'd3, 2'd0, 8'hA8},
            '{8'hB5, 3'd3, 2'd1, 8'h16},
            '{8'hB5, 3'd3, 2'd2, 8'hF6},
            '{8'hB5, 3'd3, 2'd3, 8'hB6},
            '{8'h5A, 3'd0, 2'd0, 8'h5A},
            '{8'h5A, 3'd0, 2'd1, 8'h5A},
            '{8'h5A, 3'd0, 2'd2, 8'h5A},
            '{8'h5A, 3'd0, 2'd3, 8'h5A},
            '{8'h80, 3'd1, 2'd0, 8'h00},
            '{8'h80, 3'd7, 2'd2, 8'hFF},
            '{8'h80, 3'd7, 2'd1, 8'h01},
            '{8'h01, 3'd7, 2'd3, 8'h02},
            '{8'h7F, 3'd5, 2'd2, 8'h03}
        };

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
        in_mode = '0; in_tag = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_zero", out_zero, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (dv[i]) send(dv[i].d, dv[i].s, dv[i].m, dv[i].e, 1'b1, w);
        drain();

        t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom); s = 3'($urandom); m = 2'($urandom);
            send(d, s, m, ref_shift(d, int'(s), m), 1'b1, w);
        end
        chk("stream_cycles", cyc - t0, 20);
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(8'hC3 + 8'(i), 3'(i + 1), 2'(i), ref_shift(8'hC3 + 8'(i), i + 1, 2'(i)), 1'b0, w);
            chk("fill_accept_wait", w, 0);
        end
        in_data = 8'h96; in_shamt = 3'd2; in_mode = 2'd3; in_tag = tag_ctr; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h96, 3'd2, 2'd3, 8'hA5, 1'b0, w);
        chk("drain_accept_wait", w, 0);
        for (int i = 0; i < 4; i++) begin
            send(8'h11 << i, 3'(i), 2'd0, 8'(8'h11 << (2 * i)), 1'b0, w);
        end
        drain();

        out_ready = 1'b0;
        send(8'hF0, 3'd4, 2'd1, 8'h0F, 1'b0, w);
        send(8'h0F, 3'd4, 2'd0, 8'hF0, 1'b0, w);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_data", out_data, 0);
        sb.delete();
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_word", out_valid, 0);
        end
        @(posedge clk); #1;

        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = 8'($urandom); s = 3'($urandom); m = 2'($urandom);
            send(d, s, m, ref_shift(d, int'(s), m), 1'b0, w);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
